// File: rtl/led_pkg.sv
// Shared constants and state encoding for the LED bar-graph tracker.
// Also holds the target clamp used when decoding the NIOS PIO word.
package led_pkg;

  localparam int SUB_STEPS = 16;
  localparam int MAX_LEVEL = 10;
  localparam int POS_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  // Requested levels above the bar length saturate at a full bar.
  function automatic logic [3:0] clamp_level(input logic [3:0] raw);
    logic [3:0] res;
    if (raw > 4'(MAX_LEVEL)) begin
      res = 4'(MAX_LEVEL);
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Fixed-rate strobe generator: one-cycle pulse every DIV clocks.
// Shared with the hex and accelerometer pollers.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] PRELAST = CW'(DIV - 2);

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Wrapping counter; the strobe is registered one count early so it is high exactly while cnt_r == DIV-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
      tick_r <= (cnt_r == PRELAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/led_level_tracker.sv
// Animated LED bar graph: walks the displayed position toward the commanded
// level in sub-LED steps, fades the leading LED and PWM-dims the whole bar.
module led_level_tracker
  import led_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int STEP_HZ  = 100,
  parameter int NUM_LEDS = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [9:0]          level_in,
  output logic [NUM_LEDS-1:0] ledr,
  output logic                busy
);

  localparam int DIV = CLK_HZ / STEP_HZ;

  logic [7:0]          level_r;
  logic                tick_s;
  logic [3:0]          tgt_s;
  logic [3:0]          bright_s;
  logic [POS_W-1:0]    goal_s;
  logic [POS_W-1:0]    pos_r;
  logic [3:0]          whole_s;
  logic [3:0]          frac_s;
  logic [7:0]          pwm_r;
  logic [7:0]          duty_full_s;
  logic [7:0]          duty_part_s;
  logic [NUM_LEDS-1:0] ledr_s;
  logic [NUM_LEDS-1:0] ledr_r;
  state_e              state_s;
  state_e              state_r;
  logic                unused_level_s;

  // The top two PIO bits carry nothing for this block.
  assign unused_level_s = ^level_in[9:8];

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick_s)
  );

  // Capture the PIO word once; it already lives in this clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_r <= 8'd0;
    end else begin
      level_r <= level_in[7:0];
    end
  end

  assign tgt_s    = clamp_level(level_r[3:0]);
  assign bright_s = level_r[7:4];
  assign goal_s   = POS_W'(int'(tgt_s) * SUB_STEPS);
  assign whole_s  = pos_r[7:4];
  assign frac_s   = pos_r[3:0];

  // bright*17 spreads 0..15 across 0..255; the leading LED scales with the sub-step.
  assign duty_full_s = 8'(bright_s) * 8'd17;
  assign duty_part_s = 8'(frac_s) * 8'(bright_s);

  // Direction is recomputed every cycle, so a new target reverses at the next tick.
  always_comb begin
    state_s = IDLE;
    if (pos_r < goal_s) begin
      state_s = UP;
    end else if (pos_r > goal_s) begin
      state_s = DOWN;
    end else begin
      state_s = IDLE;
    end
  end

  // Position FSM: steps one sub-LED per tick toward the goal, never past it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      pos_r   <= '0;
    end else begin
      state_r <= state_s;
      case (state_s)
        UP: begin
          if (tick_s) begin
            pos_r <= pos_r + POS_W'(1);
          end else begin
            pos_r <= pos_r;
          end
        end
        DOWN: begin
          if (tick_s) begin
            pos_r <= pos_r - POS_W'(1);
          end else begin
            pos_r <= pos_r;
          end
        end
        IDLE: begin
          pos_r <= pos_r;
        end
        default: begin
          pos_r <= pos_r;
        end
      endcase
    end
  end

  // Free-running PWM phase shared by every LED.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_r <= 8'd0;
    end else begin
      pwm_r <= pwm_r + 8'd1;
    end
  end

  // Fully lit LEDs below the leading one, a partial-duty leading LED, nothing above.
  always_comb begin
    ledr_s = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (4'(i) < whole_s) begin
        ledr_s[i] = (pwm_r < duty_full_s);
      end else if (4'(i) == whole_s) begin
        ledr_s[i] = (pwm_r < duty_part_s);
      end else begin
        ledr_s[i] = 1'b0;
      end
    end
  end

  // Output register for the LED pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ledr_r <= '0;
    end else begin
      ledr_r <= ledr_s;
    end
  end

  assign ledr = ledr_r;
  assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_led_level_tracker.sv
// Self-checking bench for led_level_tracker: per-cycle scoreboard against a
// behavioural model, plus a table of target/brightness moves and corner sequences.
module tb_led_level_tracker;

  localparam int CLK_HZ  = 1600;
  localparam int STEP_HZ = 100;
  localparam int NLED    = 10;
  localparam int DIV     = CLK_HZ / STEP_HZ;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [9:0]      level_in = 10'd0;
  logic [NLED-1:0] ledr;
  logic            busy;

  led_level_tracker #(
    .CLK_HZ   (CLK_HZ),
    .STEP_HZ  (STEP_HZ),
    .NUM_LEDS (NLED)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .level_in (level_in),
    .ledr     (ledr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Behavioural reference: what the outputs must show after each rising edge.
  typedef struct packed {
    logic [NLED-1:0] ledr;
    logic            busy;
  } exp_t;

  exp_t       sb_q[$];
  logic [9:0] m_level;
  int         m_cnt;
  int         m_pos;
  int         m_pwm;

  always @(posedge clk or negedge reset_n) begin
    int              tgt, goal, whole, frac, br, nxt;
    logic [NLED-1:0] nl;
    logic            nb;
    if (!reset_n) begin
      m_level = 10'd0;
      m_cnt   = 0;
      m_pos   = 0;
      m_pwm   = 0;
      sb_q.delete();
    end else begin
      tgt  = (m_level[3:0] > 4'd10) ? 10 : int'(m_level[3:0]);
      goal = tgt * 16;
      br   = int'(m_level[7:4]);
      whole = m_pos / 16;
      frac  = m_pos % 16;
      nxt  = m_pos;
      if (m_cnt == DIV - 1) begin
        if (m_pos < goal) nxt = m_pos + 1;
        else if (m_pos > goal) nxt = m_pos - 1;
      end
      for (int i = 0; i < NLED; i++) begin
        nl[i] = ((i < whole) && (m_pwm < br * 17)) || ((i == whole) && (m_pwm < frac * br));
      end
      nb      = (m_pos != goal);
      m_pos   = nxt;
      m_pwm   = (m_pwm + 1) % 256;
      m_cnt   = (m_cnt + 1) % DIV;
      m_level = level_in;
      sb_q.push_back({nl, nb});
    end
  end

  // Every falling edge: zero outputs under reset, otherwise the model's prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      check("rst_ledr", 32'(ledr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end else if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("cyc_ledr", 32'(ledr), 32'(e.ledr));
      check("cyc_busy", 32'(busy), 32'(e.busy));
    end
  end

  int on_cnt[NLED];

  task automatic run_busy(input int cycles, output int hi, output int first_hi);
    hi = 0;
    first_hi = 0;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        hi++;
        if (first_hi == 0) first_hi = c;
      end
    end
  endtask

  task automatic measure_duty();
    for (int i = 0; i < NLED; i++) on_cnt[i] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int i = 0; i < NLED; i++) if (ledr[i] === 1'b1) on_cnt[i]++;
    end
  endtask

  typedef struct {
    logic [9:0] level;
    int         n_ticks;
    int         n_lit;
    int         duty;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int hi, first_hi, lo_b, hi_b, cyc;
    bit found;

    vecs[0] = '{10'h0F3,  48,  3, 255};   // up to 3 at full brightness
    vecs[1] = '{10'h0FC, 112, 10, 255};   // target 12 saturates at 10 LEDs
    vecs[2] = '{10'h0F0, 160,  0,   0};   // all the way down
    vecs[3] = '{10'h005,  80,  5,   0};   // bright 0 keeps the bar dark
    vecs[4] = '{10'h015,   0,  5,  17};   // brightness only, no movement
    vecs[5] = '{10'h3F5,   0,  5, 255};   // upper PIO bits ignored

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;

    repeat (1000) begin
      @(negedge clk);
      check("idle_ledr", 32'(ledr), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Reversal: climb to pos 20, then command 0 and expect a 20-tick descent.
    level_in = 10'h0F5;
    found = 1'b0;
    for (int c = 0; c < 20 * 16 + 40; c++) begin
      @(negedge clk);
      if (m_pos == 20) begin
        found = 1'b1;
        break;
      end
    end
    check("rev_reach20", 32'(found), 32'd1);
    level_in = 10'h0F0;
    cyc = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cyc++;
    end
    check_range("rev_down_cycles", cyc, 318, 322);
    check("rev_end_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 6; v++) begin
      level_in = vecs[v].level;
      run_busy(vecs[v].n_ticks * 16 + 40, hi, first_hi);
      if (vecs[v].n_ticks == 0) begin
        lo_b = 0;
        hi_b = 0;
      end else begin
        lo_b = vecs[v].n_ticks * 16 - 15;
        hi_b = vecs[v].n_ticks * 16;
        check($sformatf("v%0d_busy_rise", v), 32'(first_hi), 32'd2);
      end
      check_range($sformatf("v%0d_busy_cycles", v), hi, lo_b, hi_b);
      measure_duty();
      for (int i = 0; i < NLED; i++) begin
        check($sformatf("v%0d_duty_led%0d", v, i), 32'(on_cnt[i]),
              32'((i < vecs[v].n_lit) ? vecs[v].duty : 0));
      end
    end

    // Mid-move reset: bar must restart from 0 and take the full 160 ticks.
    level_in = 10'h0FA;
    repeat (200) @(negedge clk);
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    run_busy(160 * 16 + 40, hi, first_hi);
    check("rst_busy_rise", 32'(first_hi), 32'd2);
    check_range("rst_busy_cycles", hi, 160 * 16 - 15, 160 * 16);
    measure_duty();
    for (int i = 0; i < NLED; i++) begin
      check($sformatf("rst_duty_led%0d", i), 32'(on_cnt[i]), 32'd255);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
